uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 132 +++++++++++++
 tb/tb_uart_tx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter that pulls bytes from a FIFO read port with one-cycle read latency.
// Each frame walks IDLE -> REQ -> WAIT -> START -> DATA x8 -> STOP.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WIDTH        = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic             o_fifo_rd_en,
  input  logic [WIDTH-1:0] i_fifo_rd_data,
  input  logic             i_fifo_rd_valid,
  input  logic             i_fifo_empty,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (i_en && !i_fifo_empty) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A read that returns nothing drops back to IDLE without touching the line.
        if (i_fifo_rd_valid) begin
          sh_d    = i_fifo_rd_data[7:0];
          cnt_d   = CNT_MAX;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = CNT_MAX;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = CNT_MAX;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = sh_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Line value follows the next state so it switches on the same edge as the FSM.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign o_fifo_rd_en = (state_q == S_REQ);
  assign o_busy       = (state_q != S_IDLE);
  assign o_tx         = tx_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4: a FIFO model feeds bytes, a line
// decoder rebuilds each frame and compares it against the scoreboard queue.
module tb_uart_tx;

  localparam int C = 4;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_en;
  logic       o_fifo_rd_en;
  logic [7:0] i_fifo_rd_data;
  logic       i_fifo_rd_valid;
  logic       i_fifo_empty;
  logic       o_tx;
  logic       o_busy;
  logic       o_done;

  uart_tx #(.CLKS_PER_BIT(C), .WIDTH(8)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_en           (i_en),
    .o_fifo_rd_en   (o_fifo_rd_en),
    .i_fifo_rd_data (i_fifo_rd_data),
    .i_fifo_rd_valid(i_fifo_rd_valid),
    .i_fifo_empty   (i_fifo_empty),
    .o_tx           (o_tx),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] fifo[$];
  logic [7:0] sb[$];
  bit         rd_pend = 0;
  bit         novalid = 0;
  bit         prev_empty = 1;
  bit         prev_rd = 0;

  int cyc = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int low_cnt = 0;
  int busy_cnt = 0;
  int viol = 0;
  int frames = 0;

  bit         in_frame = 0;
  int         fcnt = 0;
  bit         bad = 0;
  logic [7:0] obs = 8'd0;
  logic [7:0] exp_b = 8'd0;
  int         last_stop_cyc = 0;
  int         last_gap = 0;
  bit         done_due = 0;
  bit         done_low_due = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task push_byte(input logic [7:0] b, input bit expect_tx);
    fifo.push_back(b);
    if (expect_tx) sb.push_back(b);
    i_fifo_empty = 1'b0;
  endtask

  task tick();
    logic [8:0] want;
    int idx;
    logic eb;
    prev_empty = i_fifo_empty;
    @(posedge i_clk);
    #1;
    cyc++;
    if (rd_pend && fifo.size() > 0) begin
      i_fifo_rd_data  = fifo.pop_front();
      i_fifo_rd_valid = !novalid;
    end else begin
      i_fifo_rd_valid = 1'b0;
    end
    rd_pend      = o_fifo_rd_en;
    i_fifo_empty = (fifo.size() == 0);

    if (o_fifo_rd_en === 1'b1) begin
      rd_cnt++;
      if (prev_empty || prev_rd) viol++;
    end
    prev_rd = (o_fifo_rd_en === 1'b1);
    if (o_done === 1'b1) done_cnt++;
    if (o_tx !== 1'b1) low_cnt++;
    if (o_busy === 1'b1) busy_cnt++;

    if (done_due) begin
      check("done_pulse", o_done, 1);
      check("idle_after_frame", o_busy, 0);
      done_due = 0;
      done_low_due = 1;
    end else if (done_low_due) begin
      check("done_one_cycle", o_done, 0);
      done_low_due = 0;
    end

    if (!in_frame && o_tx === 1'b0) begin
      in_frame = 1;
      fcnt = 0;
      bad = 0;
      obs = 8'd0;
      last_gap = cyc - last_stop_cyc - 1;
      exp_b = (sb.size() > 0) ? sb[0] : 8'd0;
    end
    if (in_frame) begin
      idx = fcnt / C;
      eb = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : exp_b[idx-1];
      if (o_tx !== eb) bad = 1;
      if ((fcnt % C) == C / 2 && idx >= 1 && idx <= 8) obs[idx-1] = o_tx;
      fcnt++;
      if (fcnt == 10 * C) begin
        in_frame = 0;
        last_stop_cyc = cyc;
        done_due = 1;
        frames++;
        want = (sb.size() > 0) ? {1'b0, sb.pop_front()} : 9'h1FF;
        check("frame_data", {1'b0, obs}, want);
        check("frame_shape", bad, 0);
      end
    end
  endtask

  task wait_frames(input int n, input int budget);
    int start;
    int k;
    start = frames;
    k = 0;
    while ((frames - start) < n && k < budget) begin
      tick();
      k++;
    end
    check("wait_frames", frames - start, n);
    tick();
  endtask

  task wait_start(input int budget);
    int k;
    k = 0;
    while (!in_frame && k < budget) begin
      tick();
      k++;
    end
    check("wait_start", in_frame, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, dn0, lo0, bz0, fr0, t3;
    i_rst = 1'b1;
    i_en = 1'b1;
    i_fifo_rd_data = 8'd0;
    i_fifo_rd_valid = 1'b0;
    i_fifo_empty = 1'b1;
    repeat (3) tick();
    check("rst_tx", o_tx, 1);
    check("rst_busy", o_busy, 0);
    check("rst_rd_en", o_fifo_rd_en, 0);
    check("rst_done", o_done, 0);
    i_rst = 1'b0;
    repeat (5) tick();
    check("idle_empty_busy", o_busy, 0);

    // Single byte 0x55 with latency and frame length
    rd0 = rd_cnt; dn0 = done_cnt;
    push_byte(8'h55, 1);
    tick();
    check("lat_req_rd_en", o_fifo_rd_en, 1);
    tick();
    check("lat_wait_rd_en", o_fifo_rd_en, 0);
    check("lat_wait_busy", o_busy, 1);
    check("lat_wait_tx", o_tx, 1);
    tick();
    check("lat_start_tx", o_tx, 0);
    t3 = cyc;
    wait_frames(1, 100);
    check("frame_len", last_stop_cyc - t3, 10 * C - 1);
    check("single_rd_pulses", rd_cnt - rd0, 1);
    check("single_done_pulses", done_cnt - dn0, 1);

    // Back-to-back 0xA5, 0x3C
    rd0 = rd_cnt; dn0 = done_cnt;
    push_byte(8'hA5, 1);
    push_byte(8'h3C, 1);
    wait_frames(2, 300);
    check("b2b_gap", last_gap, 3);
    check("b2b_rd_pulses", rd_cnt - rd0, 2);
    check("b2b_done_pulses", done_cnt - dn0, 2);

    // Enable gating
    i_en = 1'b0;
    push_byte(8'h96, 1);
    rd0 = rd_cnt; lo0 = low_cnt; bz0 = busy_cnt;
    repeat (50) tick();
    check("gate_no_rd", rd_cnt - rd0, 0);
    check("gate_tx_high", low_cnt - lo0, 0);
    check("gate_not_busy", busy_cnt - bz0, 0);
    i_en = 1'b1;
    tick();
    check("gate_t1_tx", o_tx, 1);
    tick();
    check("gate_t2_tx", o_tx, 1);
    tick();
    check("gate_t3_tx", o_tx, 0);
    wait_frames(1, 100);

    // Reset during data bit 3 of 0xFF
    push_byte(8'hFF, 1);
    wait_start(20);
    repeat (17) tick();
    check("mid_bit3_tx", o_tx, 1);
    check("mid_bit3_busy", o_busy, 1);
    in_frame = 0;
    if (sb.size() > 0) void'(sb.pop_front());
    i_rst = 1'b1;
    tick();
    check("abort_tx", o_tx, 1);
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    i_rst = 1'b0;
    rd0 = rd_cnt; lo0 = low_cnt; bz0 = busy_cnt; dn0 = done_cnt;
    repeat (60) tick();
    check("abort_no_rd", rd_cnt - rd0, 0);
    check("abort_no_line", low_cnt - lo0, 0);
    check("abort_no_busy", busy_cnt - bz0, 0);
    check("abort_no_done", done_cnt - dn0, 0);

    // Missing read valid
    novalid = 1;
    push_byte(8'h12, 0);
    dn0 = done_cnt; lo0 = low_cnt;
    tick();
    check("nv_req", o_fifo_rd_en, 1);
    tick();
    check("nv_wait_busy", o_busy, 1);
    tick();
    check("nv_back_idle", o_busy, 0);
    check("nv_tx", o_tx, 1);
    repeat (10) tick();
    check("nv_no_done", done_cnt - dn0, 0);
    check("nv_no_line", low_cnt - lo0, 0);
    novalid = 0;

    // Enable drop mid-frame
    rd0 = rd_cnt; dn0 = done_cnt; fr0 = frames;
    push_byte(8'hC3, 1);
    push_byte(8'h5A, 1);
    wait_start(20);
    repeat (8) tick();
    i_en = 1'b0;
    wait_frames(1, 100);
    repeat (30) tick();
    check("endrop_frames", frames - fr0, 1);
    check("endrop_rd", rd_cnt - rd0, 1);
    check("endrop_done", done_cnt - dn0, 1);
    check("endrop_fifo_left", fifo.size(), 1);
    check("endrop_idle", o_busy, 0);
    i_en = 1'b1;
    wait_frames(1, 100);

    check("sb_drained", sb.size(), 0);
    check("rd_en_protocol", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
